// File: rtl/mitchell_mult_seq.sv
// mitchell_mult_seq
//   Sequential unsigned WIDTH x WIDTH multiplier with a runtime mode select.
//   mode=0 computes the exact product by iterative shift-add, one step per
//   cycle with the multiplier LSB first. mode=1 computes the Mitchell
//   logarithmic approximation in two cycles.
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   Operands transfer when in_valid && in_ready, and in_ready is high only in IDLE.
//   The result transfers when out_valid && out_ready. p and p_mode are held until then.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, mode sampled on accept)
//   mode                 0 = exact, 1 = Mitchell approximate
//   a, b                 unsigned operands, WIDTH bits
//   out_valid/out_ready  result handshake
//   p                    product, 2*WIDTH bits
//   p_mode               mode that produced p
module mitchell_mult_seq #(
    parameter int WIDTH  = 8,
    parameter int FRAC_W = WIDTH - 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               p_mode
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = FRAC_W + 2 + 2 * WIDTH;
    localparam logic [KW-1:0] LAST_STEP = KW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXACT, MITCH, DONE} state_t;
    state_t state;

    // exact datapath
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [KW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc_next;

    // Mitchell datapath
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [KW-1:0]      ka;
    logic [KW-1:0]      kb;
    logic [FRAC_W-1:0]  xa;
    logic [FRAC_W-1:0]  xb;
    logic               zero_op;
    logic [FRAC_W:0]    s_sum;
    logic [KW:0]        k_sum;
    logic [PW-1:0]      mant;
    logic [PW-1:0]      scaled;
    logic [2*WIDTH-1:0] mitch_p;

    // Position of the most significant set bit (0 when v == 0).
    function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) k = KW'(i);
        return k;
    endfunction

    // Fraction bits below the leading one, left-aligned to FRAC_W bits.
    // Bits shifted out at the bottom are truncated. The leading one lands
    // at bit FRAC_W and is dropped by the narrowing cast.
    function automatic logic [FRAC_W-1:0] frac(input logic [WIDTH-1:0] v,
                                               input logic [KW-1:0]    k);
        logic [WIDTH+FRAC_W-1:0] t;
        t = {v, {FRAC_W{1'b0}}} >> k;
        return FRAC_W'(t);
    endfunction

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Mantissa is (1+s) when s<1, or 2*s when s>=1. It has FRAC_W fraction
    // bits. Scaling by 2^(ka+kb) and dropping the fraction truncates toward zero.
    always_comb begin
        s_sum = {1'b0, xa} + {1'b0, xb};
        k_sum = {1'b0, ka} + {1'b0, kb};
        if (s_sum[FRAC_W])
            mant = {{(PW-FRAC_W-2){1'b0}}, s_sum, 1'b0};
        else
            mant = {{(PW-FRAC_W-1){1'b0}}, s_sum} | (PW'(1) << FRAC_W);
        scaled  = mant << k_sum;
        mitch_p = (2*WIDTH)'(scaled >> FRAC_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p         <= '0;
            p_mode    <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            ka        <= '0;
            kb        <= '0;
            xa        <= '0;
            xb        <= '0;
            zero_op   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, a};
                        mplier   <= b;
                        op_a     <= a;
                        op_b     <= b;
                        cnt      <= '0;
                        state    <= mode ? MITCH : EXACT;
                    end
                end
                EXACT: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        p         <= acc_next;
                        p_mode    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                MITCH: begin
                    if (cnt == '0) begin
                        // first cycle: leading-one detect and fraction extraction
                        ka      <= lod(op_a);
                        kb      <= lod(op_b);
                        xa      <= frac(op_a, lod(op_a));
                        xb      <= frac(op_b, lod(op_b));
                        zero_op <= (op_a == '0) || (op_b == '0);
                        cnt     <= cnt + 1'b1;
                    end else begin
                        p         <= zero_op ? '0 : mitch_p;
                        p_mode    <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mitchell_mult_seq.sv
module tb_mitchell_mult_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    logic        in_valid8 = 1'b0, in_ready8, mode8 = 1'b0;
    logic        out_valid8, out_ready8 = 1'b0, p_mode8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    logic        in_valid16 = 1'b0, in_ready16, mode16 = 1'b0;
    logic        out_valid16, out_ready16 = 1'b0, p_mode16;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;

    int tests = 0;
    int fails = 0;

    mitchell_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .mode(mode8), .a(a8), .b(b8), .out_valid(out_valid8),
        .out_ready(out_ready8), .p(p8), .p_mode(p_mode8)
    );

    mitchell_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .mode(mode16), .a(a16), .b(b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .p(p16), .p_mode(p_mode16)
    );

    // Mitchell reference written from the log-domain definition with
    // integer division standing in for truncation.
    function automatic longint unsigned mitch_ref(input longint unsigned x,
                                                  input longint unsigned y,
                                                  input int f);
        int kx, ky;
        longint unsigned fx, fy, s, one;
        if (x == 0 || y == 0) return 0;
        kx = 0;
        while ((x >> (kx + 1)) != 0) kx++;
        ky = 0;
        while ((y >> (ky + 1)) != 0) ky++;
        one = 64'd1 << f;
        fx = ((x - (64'd1 << kx)) * one) / (64'd1 << kx);
        fy = ((y - (64'd1 << ky)) * one) / (64'd1 << ky);
        s = fx + fy;
        if (s < one) return ((one + s) * (64'd1 << (kx + ky))) / one;
        return (s * (64'd1 << (kx + ky + 1))) / one;
    endfunction

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic m,
                       output logic [15:0] pv, output logic pm, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid8 = 1'b1; a8 = av; b8 = bv; mode8 = m; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        pv = p8;
        pm = p_mode8;
        @(posedge clk); #1;
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic m,
                        output logic [31:0] pv, output logic pm, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready16 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid16 = 1'b1; a16 = av; b16 = bv; mode16 = m; out_ready16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); mode16 = 1'($urandom);
        lat = 0;
        while (!out_valid16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        pv = p16;
        pm = p_mode16;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic seen;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || p8 !== 16'd0 || p_mode8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b p=%0d p_mode=%b, want 0 1 0 0",
                     out_valid8, in_ready8, p8, p_mode8);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'd200; b8 = 8'd200; mode8 = 1'b0; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        tests++;
        if (in_ready8 !== 1'b0) begin
            fails++;
            $display("FAIL accept_drop_ready: in_ready=%b want 0", in_ready8);
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || p8 !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid_exact: out_valid=%b in_ready=%b p=%0d, want 0 1 0",
                     out_valid8, in_ready8, p8);
        end
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid8 || p8 != 16'd0) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_stale: stale result seen=%b want 0", seen);
        end
    endtask

    task automatic test_exact();
        logic [7:0] ca[6] = '{8'd0, 8'd123, 8'd255, 8'd1, 8'd200, 8'd17};
        logic [7:0] cb[6] = '{8'd77, 8'd0, 8'd255, 8'd200, 8'd1, 8'd3};
        logic [7:0] av, bv;
        logic [15:0] pv;
        logic pm;
        int lat;
        for (int i = 0; i < 1006; i++) begin
            if (i < 6) begin
                av = ca[i]; bv = cb[i];
            end else begin
                av = 8'($urandom_range(0, 255)); bv = 8'($urandom_range(0, 255));
            end
            op8(av, bv, 1'b0, pv, pm, lat);
            tests++;
            if (pv !== 16'(int'(av) * int'(bv))) begin
                fails++;
                $display("FAIL exact_product %0d*%0d: got %0d want %0d", av, bv, pv, int'(av) * int'(bv));
            end
            tests++;
            if (lat !== 8 || pm !== 1'b0) begin
                fails++;
                $display("FAIL exact_latency %0d*%0d: lat=%0d p_mode=%b want 8 0", av, bv, lat, pm);
            end
        end
    endtask

    task automatic test_mitchell();
        logic [7:0]  ca[5] = '{8'd3, 8'd255, 8'd64, 8'd0, 8'd77};
        logic [7:0]  cb[5] = '{8'd3, 8'd255, 8'd200, 8'd77, 8'd0};
        logic [15:0] ce[5] = '{16'd8, 16'd65024, 16'd12800, 16'd0, 16'd0};
        logic [15:0] pv;
        logic pm;
        int lat;
        for (int i = 0; i < 5; i++) begin
            op8(ca[i], cb[i], 1'b1, pv, pm, lat);
            tests++;
            if (pv !== ce[i] || pm !== 1'b1 || lat !== 2) begin
                fails++;
                $display("FAIL mitch_corner %0d*%0d: p=%0d p_mode=%b lat=%0d want %0d 1 2",
                         ca[i], cb[i], pv, pm, lat, ce[i]);
            end
        end
    endtask

    task automatic test_mitchell_bound();
        logic [7:0] av, bv;
        logic [15:0] pv;
        logic pm;
        int lat;
        longint unsigned ex, ref_p;
        for (int i = 0; i < 1000; i++) begin
            av = 8'($urandom_range(0, 255)); bv = 8'($urandom_range(0, 255));
            op8(av, bv, 1'b1, pv, pm, lat);
            ex = longint'(av) * longint'(bv);
            ref_p = mitch_ref(av, bv, 7);
            tests++;
            if (longint'(pv) !== ref_p || lat !== 2 || pm !== 1'b1) begin
                fails++;
                $display("FAIL mitch_model %0d*%0d: p=%0d lat=%0d p_mode=%b want %0d 2 1",
                         av, bv, pv, lat, pm, ref_p);
            end
            tests++;
            if (!(longint'(pv) <= ex && (ex - longint'(pv)) * 1000 <= 112 * ex + 8 * 1000)) begin
                fails++;
                $display("FAIL mitch_bound %0d*%0d: p=%0d exact=%0d", av, bv, pv, ex);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard;
        logic seen;
        @(negedge clk);
        in_valid8 = 1'b1; a8 = 8'd13; b8 = 8'd11; mode8 = 1'b0; out_ready8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        guard = 0;
        while (!out_valid8 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        tests++;
        if (out_valid8 !== 1'b1) begin
            fails++;
            $display("FAIL bp_result_timeout: out_valid=%b want 1", out_valid8);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid8 = 1'b1; a8 = 8'd200; b8 = 8'd250; mode8 = 1'b1;
            tests++;
            if (out_valid8 !== 1'b1 || p8 !== 16'd143 || in_ready8 !== 1'b0 || p_mode8 !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b p=%0d in_ready=%b p_mode=%b want 1 143 0 0",
                         i, out_valid8, p8, in_ready8, p_mode8);
            end
        end
        @(negedge clk);
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid8, in_ready8);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_capture: extra result seen=%b want 0", seen);
        end
    endtask

    task automatic test_back_to_back16();
        logic [15:0] av, bv;
        logic [31:0] pv;
        logic pm, m;
        int lat;
        longint unsigned want;
        op16(16'hFFFF, 16'hFFFF, 1'b0, pv, pm, lat);
        tests++;
        if (pv !== 32'd4294836225 || lat !== 16 || pm !== 1'b0) begin
            fails++;
            $display("FAIL w16_max: p=%0d lat=%0d p_mode=%b want 4294836225 16 0", pv, lat, pm);
        end
        for (int i = 0; i < 60; i++) begin
            av = 16'($urandom); bv = 16'($urandom); m = 1'($urandom);
            op16(av, bv, m, pv, pm, lat);
            want = m ? mitch_ref(av, bv, 15) : longint'(av) * longint'(bv);
            tests++;
            if (longint'(pv) !== want || pm !== m || lat !== (m ? 2 : 16)) begin
                fails++;
                $display("FAIL w16_mixed %0d*%0d mode=%b: p=%0d p_mode=%b lat=%0d want %0d",
                         av, bv, m, pv, pm, lat, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_mitchell();
        test_mitchell_bound();
        test_backpressure();
        test_back_to_back16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
